// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps S through 0..3, settles, samples Z into a 4-bit word.
// One VALID pulse per completed scan; runs single-shot on START or back-to-back under CONT.
module mux4_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       CONT,
    input  logic       Z,
    output logic [1:0] S,
    output logic [3:0] DATA,
    output logic       VALID,
    output logic       BUSY
);

    typedef enum logic [1:0] {StIdle, StSettle, StSample} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [2:0]       shadow_q, shadow_d;
    logic [3:0]       data_q, data_d;
    logic             valid_q, valid_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                sel_d = 2'd0;
                cnt_d = '0;
                if (START) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                // Counter is cleared on exit so it never reaches SETTLE_CYCLES.
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StSample: begin
                cnt_d = '0;
                unique case (sel_q)
                    2'd0: begin
                        shadow_d[0] = Z;
                        sel_d       = 2'd1;
                        state_d     = StSettle;
                    end
                    2'd1: begin
                        shadow_d[1] = Z;
                        sel_d       = 2'd2;
                        state_d     = StSettle;
                    end
                    2'd2: begin
                        shadow_d[2] = Z;
                        sel_d       = 2'd3;
                        state_d     = StSettle;
                    end
                    default: begin
                        // Whole word commits at once so DATA is never partially updated.
                        data_d  = {Z, shadow_q};
                        valid_d = 1'b1;
                        sel_d   = 2'd0;
                        state_d = CONT ? StSettle : StIdle;
                    end
                endcase
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            sel_q    <= 2'd0;
            shadow_q <= 3'd0;
            data_q   <= 4'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign S     = sel_q;
    assign DATA  = data_q;
    assign VALID = valid_q;
    assign BUSY  = (state_q != StIdle);

endmodule
